// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : shared types and ASCII constants for the word-game front end
// Rev 1.0
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } entry_state_t;

    localparam logic [7:0] ASCII_A       = 8'h41;
    localparam logic [7:0] ASCII_Z       = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET   = 8'h20;
    localparam int         LETTER_COUNT  = 26;

endpackage

`default_nettype wire

// File: rtl/ascii_norm.sv
// ============================================================================
// ascii_norm : folds an ASCII key code to an uppercase letter and 0..25 index
// Rev 1.0
// ============================================================================
`default_nettype none

module ascii_norm
    import game_pkg::*;
(
    input  logic [7:0] code_i,
    output logic [7:0] letter_o,
    output logic       is_letter_o,
    output logic [4:0] index_o
);

    logic w_is_upper;
    logic w_is_lower;

    assign w_is_upper  = (code_i >= ASCII_A) && (code_i <= ASCII_Z);
    assign w_is_lower  = (code_i >= ASCII_LOWER_A) && (code_i <= ASCII_LOWER_Z);
    assign is_letter_o = w_is_upper | w_is_lower;
    assign letter_o    = w_is_lower ? (code_i - CASE_OFFSET) : code_i;

    // 'A'..'Z' occupy 0x41..0x5A, so the low five bits run 1..26.
    assign index_o     = letter_o[4:0] - 5'd1;

endmodule

`default_nettype wire

// File: rtl/word_entry.sv
// ============================================================================
// word_entry : key-strobe front end building the secret word and filtering guesses
// Rev 1.0
// ============================================================================
`default_nettype none

module word_entry
    import game_pkg::*;
#(
    parameter int WORD_LEN = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [7:0]            key_code,
    input  logic                  key_del,
    input  logic                  key_enter,
    input  logic                  game_end,
    output logic [8*WORD_LEN-1:0] setWord,
    output logic                  toggle_state,
    output logic [7:0]            guess,
    output logic                  guess_valid,
    output logic [2:0]            count,
    output logic                  bad_key,
    output logic [1:0]            phase
);

    localparam logic [2:0] c_FULL_COUNT = 3'(WORD_LEN);

    entry_state_t              state_q, state_d;
    logic [8*WORD_LEN-1:0]     word_q, word_d;
    logic [2:0]                count_q, count_d;
    logic [7:0]                guess_q, guess_d;
    logic [LETTER_COUNT-1:0]   used_q, used_d;
    logic                      toggle_q, toggle_d;
    logic                      guess_valid_q, guess_valid_d;
    logic                      bad_key_q, bad_key_d;

    logic [7:0]                w_letter;
    logic                      w_is_letter;
    logic [4:0]                w_index;
    logic [LETTER_COUNT-1:0]   w_onehot;

    ascii_norm u_norm (
        .code_i      (key_code),
        .letter_o    (w_letter),
        .is_letter_o (w_is_letter),
        .index_o     (w_index)
    );

    assign w_onehot = LETTER_COUNT'(1) << w_index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SETUP;
            word_q        <= '0;
            count_q       <= '0;
            guess_q       <= '0;
            used_q        <= '0;
            toggle_q      <= 1'b0;
            guess_valid_q <= 1'b0;
            bad_key_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            count_q       <= count_d;
            guess_q       <= guess_d;
            used_q        <= used_d;
            toggle_q      <= toggle_d;
            guess_valid_q <= guess_valid_d;
            bad_key_q     <= bad_key_d;
        end
    end

    // Strobe priority throughout: enter, then delete, then letter key.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        count_d       = count_q;
        guess_d       = guess_q;
        used_d        = used_q;
        toggle_d      = 1'b0;
        guess_valid_d = 1'b0;
        bad_key_d     = 1'b0;

        unique case (state_q)
            SETUP: begin
                if (key_enter) begin
                    bad_key_d = 1'b1;
                end else if (key_del) begin
                    if (count_q != 3'd0) begin
                        word_d  = word_q >> 8;
                        count_d = count_q - 3'd1;
                    end
                end else if (key_valid) begin
                    if (w_is_letter) begin
                        word_d  = {word_q[8*WORD_LEN-9:0], w_letter};
                        count_d = count_q + 3'd1;
                        if (count_q + 3'd1 == c_FULL_COUNT) begin
                            state_d = ARMED;
                        end
                    end else begin
                        bad_key_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (key_enter) begin
                    toggle_d = 1'b1;
                    used_d   = '0;
                    state_d  = PLAY;
                end else if (key_del) begin
                    word_d  = word_q >> 8;
                    count_d = c_FULL_COUNT - 3'd1;
                    state_d = SETUP;
                end else if (key_valid) begin
                    bad_key_d = 1'b1;
                end
            end
            PLAY: begin
                if (game_end) begin
                    state_d = DONE;
                end else if (!key_enter && !key_del && key_valid) begin
                    if (!w_is_letter || ((used_q & w_onehot) != '0)) begin
                        bad_key_d = 1'b1;
                    end else begin
                        guess_d       = w_letter;
                        guess_valid_d = 1'b1;
                        used_d        = used_q | w_onehot;
                    end
                end
            end
            DONE: begin
                if (key_enter) begin
                    word_d  = '0;
                    count_d = '0;
                    guess_d = '0;
                    used_d  = '0;
                    state_d = SETUP;
                end
            end
            default: state_d = SETUP;
        endcase
    end

    assign setWord      = word_q;
    assign toggle_state = toggle_q;
    assign guess        = guess_q;
    assign guess_valid  = guess_valid_q;
    assign count        = count_q;
    assign bad_key      = bad_key_q;
    assign phase        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_word_entry.sv
// ============================================================================
// tb_word_entry : directed self-checking bench for word_entry
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_word_entry;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_del;
    logic        key_enter;
    logic        game_end;
    logic [39:0] setWord;
    logic        toggle_state;
    logic [7:0]  guess;
    logic        guess_valid;
    logic [2:0]  count;
    logic        bad_key;
    logic [1:0]  phase;

    int checks   = 0;
    int failures = 0;

    word_entry #(.WORD_LEN(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_del      (key_del),
        .key_enter    (key_enter),
        .game_end     (game_end),
        .setWord      (setWord),
        .toggle_state (toggle_state),
        .guess        (guess),
        .guess_valid  (guess_valid),
        .count        (count),
        .bad_key      (bad_key),
        .phase        (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Apply one cycle of strobes; outputs are sampled 1 ns after the edge.
    task automatic step(input logic v, input logic [7:0] code, input logic d, input logic e, input logic ge);
        key_valid = v;
        key_code  = code;
        key_del   = d;
        key_enter = e;
        game_end  = ge;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 8'h00;
        key_del   = 1'b0;
        key_enter = 1'b0;
        game_end  = 1'b0;
    endtask

    task automatic press(input logic [7:0] code);
        step(1'b1, code, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key_valid = 1'b0; key_code = 8'h00; key_del = 1'b0; key_enter = 1'b0; game_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_word",   setWord, 40'h0);
        check("rst_count",  {37'h0, count}, 40'd0);
        check("rst_phase",  {38'h0, phase}, 40'd0);
        check("rst_pulses", {37'h0, toggle_state, guess_valid, bad_key}, 40'd0);
        check("rst_guess",  {32'h0, guess}, 40'h0);

        // Asynchronous reset in the middle of entry.
        press("A"); press("P");
        check("ap_count", {37'h0, count}, 40'd2);
        check("ap_word",  setWord, 40'h4150);
        rst = 1'b1;
        #1;
        check("async_count", {37'h0, count}, 40'd0);
        check("async_word",  setWord, 40'h0);
        check("async_phase", {38'h0, phase}, 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lowercase word entry and confirm.
        press("a"); press("p"); press("p"); press("l");
        check("bad_digit_setup_pre", {37'h0, count}, 40'd4);
        press("e");
        check("apple_armed", {38'h0, phase}, 40'd1);
        check("apple_count", {37'h0, count}, 40'd5);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("apple_toggle", {39'h0, toggle_state}, 40'd1);
        check("apple_word",   setWord, 40'h4150504C45);
        check("apple_phase",  {38'h0, phase}, 40'd2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("toggle_one_cycle", {39'h0, toggle_state}, 40'd0);

        // Backspace editing, including removal from ARMED.
        pulse_reset();
        press("A"); press("P"); press("P"); press("X");
        check("appx_word", setWord, 40'h41505058);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("del_word",  setWord, 40'h415050);
        check("del_count", {37'h0, count}, 40'd3);
        press("L"); press("E");
        check("ale_armed", {38'h0, phase}, 40'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("armed_del_word",  setWord, 40'h4150504C);
        check("armed_del_count", {37'h0, count}, 40'd4);
        check("armed_del_phase", {38'h0, phase}, 40'd0);
        press("E");
        press("Q");
        check("armed_letter_bad",   {39'h0, bad_key}, 40'd1);
        check("armed_letter_count", {37'h0, count}, 40'd5);

        // Enter wins over a same-cycle letter in ARMED.
        step(1'b1, "Z", 1'b0, 1'b1, 1'b0);
        check("prio_toggle", {39'h0, toggle_state}, 40'd1);
        check("prio_no_gv",  {38'h0, guess_valid, bad_key}, 40'd0);
        check("prio_phase",  {38'h0, phase}, 40'd2);
        check("bs_word",     setWord, 40'h4150504C45);

        // Guess filtering.
        press("c");
        check("guess_c",    {32'h0, guess}, 40'h43);
        check("guess_c_gv", {38'h0, guess_valid, bad_key}, 40'b10);
        press("C");
        check("repeat_c",   {38'h0, guess_valid, bad_key}, 40'b01);
        check("repeat_c_g", {32'h0, guess}, 40'h43);
        press("5");
        check("digit_bad",  {38'h0, guess_valid, bad_key}, 40'b01);
        press("Z");
        check("guess_z",    {32'h0, guess}, 40'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("play_ignore", {37'h0, phase, toggle_state}, {37'h0, 2'd2, 1'b0});
        check("play_frozen", setWord, 40'h4150504C45);

        // Game end beats a same-cycle key; DONE ignores letters.
        step(1'b1, "B", 1'b0, 1'b0, 1'b1);
        check("end_phase", {38'h0, phase}, 40'd3);
        check("end_drop",  {38'h0, guess_valid, bad_key}, 40'd0);
        press("B");
        check("done_ignore", {30'h0, guess, guess_valid, bad_key}, {30'h0, 8'h5A, 2'b00});
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("restart_phase", {38'h0, phase}, 40'd0);
        check("restart_word",  setWord, 40'h0);
        check("restart_cg",    {29'h0, count, guess}, 40'h0);

        // Fresh word: empty delete, early enter, then mask cleared.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("del_empty", {36'h0, count, bad_key}, 40'd0);
        press("D"); press("O"); press("G");
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("early_enter_bad",   {39'h0, bad_key}, 40'd1);
        check("early_enter_phase", {38'h0, phase}, 40'd0);
        press("E"); press("S");
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("game2_word", setWord, 40'h444F474553);
        press("C");
        check("game2_c", {30'h0, guess, guess_valid, bad_key}, {30'h0, 8'h43, 2'b10});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/word_entry.md
# word_entry

Host/player front end for the word-guessing game: turns a stream of ASCII key strobes into the 40-bit secret word and a one-cycle confirm pulse, then forwards validated single-letter guesses. It is the producer side of the `setWord` / `toggle_state` / `guess` interface that the game-logic FSM consumes. It also tracks already-guessed letters so that repeated guesses never reach the game logic.

## Interface
Parameters:
- `WORD_LEN`, 5: letters per word; `setWord` width is 8*`WORD_LEN`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid this cycle.
- `key_code`  in  8  ASCII code of the key.
- `key_del`  in  1  one-cycle backspace strobe.
- `key_enter`  in  1  one-cycle confirm/restart strobe.
- `game_end`  in  1  level from game logic: the game is won or lost.
- `setWord`  out  40  secret word; first-entered letter in [39:32], last in [7:0].
- `toggle_state`  out  1  one-cycle confirm pulse to the game logic.
- `guess`  out  8  last accepted guess letter, uppercase ASCII.
- `guess_valid`  out  1  one-cycle pulse when `guess` is updated.
- `count`  out  3  number of letters currently entered (0..5).
- `bad_key`  out  1  one-cycle pulse when a key is rejected.
- `phase`  out  2  current state encoding, for display.

## Operation
- Key normalisation:
  - 'a'..'z' (0x61–0x7A) becomes code−0x20.
  - 'A'..'Z' (0x41–0x5A) passes unchanged.
  - Any other code is rejected with a `bad_key` pulse and no other effect.
- Strobe priority when several strobes are high in the same cycle: `key_enter` > `key_del` > `key_valid`. Only the highest-priority strobe acts; the others are dropped silently.
- States: SETUP=0, ARMED=1, PLAY=2, DONE=3.
- SETUP:
  - Accepted letter: `setWord <= {setWord[31:0], L}`, `count++`.
  - On reaching `count`=5, go to ARMED.
  - `key_del` with `count`>0: `setWord <= setWord >> 8`, `count--`. With `count`=0 it is ignored.
  - `key_enter` with `count`<5 produces a `bad_key` pulse.
- ARMED:
  - Further letters produce `bad_key`.
  - `key_del` removes the last letter and returns to SETUP with `count`=4.
  - `key_enter` pulses `toggle_state`, clears the used mask and goes to PLAY.
- PLAY:
  - `setWord` is frozen.
  - Accepted letter L with `used[L-'A']`=0: `guess <= L`, `guess_valid` pulse, set the used bit.
  - Accepted letter with its used bit already set produces `bad_key`; `guess` is unchanged.
  - `key_del` and `key_enter` are ignored.
  - `game_end`=1 goes to DONE. `game_end` takes precedence over a same-cycle key, which is dropped.
- DONE:
  - All letter and backspace keys are ignored.
  - `key_enter` clears `setWord`, `count`, `guess` and the used mask, then goes to SETUP.
- Used mask: 26 bits, bit i corresponds to letter 'A'+i.

## Timing
- All outputs are registered.
- Reset values: `setWord`=0, `guess`=0, `count`=0, `phase`=SETUP. `toggle_state`, `guess_valid` and `bad_key` are all 0. The used mask is 0.
- Latency: a strobe sampled at edge N updates the outputs at edge N; the new values are visible in cycle N+1. No stall and no back-pressure.
- `toggle_state` lasts exactly 1 cycle. During that cycle `setWord` already holds the final word and stays stable through all of PLAY.
- `guess_valid` and `bad_key` last exactly 1 cycle per strobe.
- Back-to-back strobes on consecutive cycles are each processed.
- Reset asserted in any state returns all outputs to their reset values immediately (asynchronously). A pulse in flight is truncated.

## Structure
- Shared package `game_pkg`:
  - `entry_state_t` enum (SETUP, ARMED, PLAY, DONE).
  - `ASCII_A`=8'h41, `ASCII_LOWER_A`=8'h61, `CASE_OFFSET`=8'h20.
- One sub-module, `ascii_norm`: combinational; input 8-bit code; outputs 8-bit uppercase letter, `is_letter`, 5-bit index.
- `word_entry` holds the FSM, the shift register, the counter and the used mask.

## Test plan
- Reset mid-entry: after "AP", assert `rst`. Required: `count`=0, `setWord`=0, `phase`=0 in the same cycle.
- Word entry: keys "apple" then enter. Required:
  - `setWord`=0x4150504C45.
  - `toggle_state` high for exactly 1 cycle.
  - `phase`=2.
- Backspace: keys "APPX", del, "LE", enter. Required: `setWord`=0x4150504C45. Then enter at `count`=3 in a fresh word → `bad_key`, `phase` stays 0.
- Guess filtering in PLAY:
  - 'c' → `guess`=0x43 with `guess_valid`.
  - 'C' again → `bad_key`, no `guess_valid`.
  - '5' → `bad_key`.
- Priority: same cycle `key_enter`+`key_valid`('Z') in ARMED. Required: `toggle_state` pulses and no guess is issued.
- End/restart: raise `game_end` in PLAY. Letter → ignored. Enter → `phase`=0, `setWord`=0, used mask cleared, so 'C' is accepted as a guess in the next game.
